// File: rtl/sobel_job_sched.sv
// Sobel job scheduler: register front end plus the raster-order job sequencer
// that feeds the Sobel datapath with one window job per interior pixel.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reg_req_i/we_i/addr_i/wdata_i, reg_gnt_o/rvalid_o/rdata_o
//                           register bus (grant tied high, response one cycle later)
//   job_valid_o/ready_i, job_x_o/job_y_o
//                           job issue handshake with window centre coordinates
//   res_valid_i             one-cycle pulse per returned result
//   busy_o, irq_o           sequencer active, level interrupt (irq_en & done)
module sobel_job_sched #(
  parameter int unsigned CoordWidth     = 16,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_req_i,
  input  logic                  reg_we_i,
  input  logic [AddrWidth-1:0]  reg_addr_i,
  input  logic [31:0]           reg_wdata_i,
  output logic                  reg_gnt_o,
  output logic                  reg_rvalid_o,
  output logic [31:0]           reg_rdata_o,
  output logic                  job_valid_o,
  input  logic                  job_ready_i,
  output logic [CoordWidth-1:0] job_x_o,
  output logic [CoordWidth-1:0] job_y_o,
  input  logic                  res_valid_i,
  output logic                  busy_o,
  output logic                  irq_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [3:0]           MaxOut     = 4'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] AddrCtrl   = AddrWidth'('h00);
  localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'('h04);
  localparam logic [AddrWidth-1:0] AddrWidthR = AddrWidth'('h08);
  localparam logic [AddrWidth-1:0] AddrHeight = AddrWidth'('h0C);
  localparam logic [AddrWidth-1:0] AddrCount  = AddrWidth'('h10);

  state_e                state_q, state_d;
  logic [CoordWidth-1:0] width_q, height_q, x_q, y_q;
  logic [31:0]           count_q, rdata_q, rd_mux;
  logic [3:0]            outst_q, outst_d;
  logic                  done_q, err_q, aborted_q, irq_en_q, abort_pend_q;
  logic                  irq_q, rvalid_q;

  logic [AddrWidth-1:0]  word_addr;
  logic                  wr, wr_ctrl, wr_status, wr_width, wr_height;
  logic                  start_req, abort_req, size_ok;
  logic                  hs, res_acc, res_stray, last_col, last_row;
  logic                  start_run, start_bad, finish;
  logic                  unused_bits;

  assign word_addr   = {reg_addr_i[AddrWidth-1:2], 2'b00};
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i[31:CoordWidth]};

  assign wr        = reg_req_i & reg_we_i;
  assign wr_ctrl   = wr && (word_addr == AddrCtrl);
  assign wr_status = wr && (word_addr == AddrStatus);
  assign wr_width  = wr && (word_addr == AddrWidthR);
  assign wr_height = wr && (word_addr == AddrHeight);
  assign start_req = wr_ctrl & reg_wdata_i[0];
  assign abort_req = wr_ctrl & reg_wdata_i[1];
  assign size_ok   = (width_q >= CoordWidth'(3)) && (height_q >= CoordWidth'(3));

  assign hs        = job_valid_o & job_ready_i;
  assign res_acc   = res_valid_i & (outst_q != '0);
  assign res_stray = res_valid_i & (outst_q == '0);
  assign outst_d   = outst_q + {3'b000, hs} - {3'b000, res_acc};
  assign last_col  = (x_q == width_q - CoordWidth'(2));
  assign last_row  = (y_q == height_q - CoordWidth'(2));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    start_bad = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (size_ok) begin
            state_d   = ISSUE;
            start_run = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort_req || (hs && last_col && last_row)) state_d = DRAIN;
      end
      DRAIN: begin
        // outst_d already folds in a return arriving this cycle
        if (outst_d == '0) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy_o      = (state_q != IDLE);
    job_valid_o = (state_q == ISSUE) && (outst_q < MaxOut);
  end

  always_comb begin
    rd_mux = '0;
    case (word_addr)
      AddrCtrl:   rd_mux = {29'b0, irq_en_q, 2'b00};
      AddrStatus: rd_mux = {28'b0, aborted_q, err_q, done_q, busy_o};
      AddrWidthR: rd_mux = 32'(width_q);
      AddrHeight: rd_mux = 32'(height_q);
      AddrCount:  rd_mux = count_q;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q      <= '0;
      height_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      abort_pend_q <= 1'b0;
      irq_q        <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      outst_q <= outst_d;
      if (res_acc && (count_q != '1)) count_q <= count_q + 32'd1;

      if (hs) begin
        if (last_col) begin
          x_q <= CoordWidth'(1);
          y_q <= y_q + CoordWidth'(1);
        end else begin
          x_q <= x_q + CoordWidth'(1);
        end
      end

      if (wr_width  && (state_q == IDLE)) width_q  <= reg_wdata_i[CoordWidth-1:0];
      if (wr_height && (state_q == IDLE)) height_q <= reg_wdata_i[CoordWidth-1:0];
      if (wr_ctrl) irq_en_q <= reg_wdata_i[2];

      if (wr_status) begin
        if (reg_wdata_i[1]) done_q    <= 1'b0;
        if (reg_wdata_i[2]) err_q     <= 1'b0;
        if (reg_wdata_i[3]) aborted_q <= 1'b0;
      end

      // Hardware events are ordered after W1C so a same-cycle set wins
      if (start_run) begin
        count_q      <= '0;
        done_q       <= 1'b0;
        aborted_q    <= 1'b0;
        abort_pend_q <= 1'b0;
        x_q          <= CoordWidth'(1);
        y_q          <= CoordWidth'(1);
      end
      if (start_bad) begin
        done_q <= 1'b1;
        err_q  <= 1'b1;
      end
      if (res_stray) err_q <= 1'b1;
      if (abort_req && (state_q != IDLE)) abort_pend_q <= 1'b1;
      if (finish) begin
        done_q       <= 1'b1;
        abort_pend_q <= 1'b0;
        if (abort_pend_q || abort_req) aborted_q <= 1'b1;
      end

      irq_q    <= irq_en_q & done_q;
      rvalid_q <= reg_req_i;
      rdata_q  <= (reg_req_i && !reg_we_i) ? rd_mux : '0;
    end
  end

  assign reg_gnt_o    = 1'b1;
  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign job_x_o      = x_q;
  assign job_y_o      = y_q;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_sobel_job_sched.sv
// Self-checking bench for sobel_job_sched: register table vectors followed by
// hand-written run sequences (normal run, credit stall, backpressure,
// degenerate sizes, abort, stray results, reset mid-run).
module tb_sobel_job_sched;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_req_i = 1'b0, reg_we_i = 1'b0;
  logic [AW-1:0] reg_addr_i = '0;
  logic [31:0]   reg_wdata_i = '0;
  logic          reg_gnt_o, reg_rvalid_o;
  logic [31:0]   reg_rdata_o;
  logic          job_valid_o, job_ready_i, res_valid_i, busy_o, irq_o;
  logic [CW-1:0] job_x_o, job_y_o;

  logic rand_ready = 1'b0, fixed_ready = 1'b0, rnd_ready = 1'b0;
  logic ret_en = 1'b0, auto_res = 1'b0, man_res = 1'b0, stab_en = 1'b0;

  assign job_ready_i = rand_ready ? rnd_ready : fixed_ready;
  assign res_valid_i = auto_res | man_res;

  always #5 clk = ~clk;

  sobel_job_sched #(
    .CoordWidth(CW),
    .MaxOutstanding(3),
    .AddrWidth(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .reg_req_i(reg_req_i),
    .reg_we_i(reg_we_i),
    .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_gnt_o(reg_gnt_o),
    .reg_rvalid_o(reg_rvalid_o),
    .reg_rdata_o(reg_rdata_o),
    .job_valid_o(job_valid_o),
    .job_ready_i(job_ready_i),
    .job_x_o(job_x_o),
    .job_y_o(job_y_o),
    .res_valid_i(res_valid_i),
    .busy_o(busy_o),
    .irq_o(irq_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Job monitor / result returner: everything here changes on the falling edge
  int cyc = 0;
  int stab_bad = 0;
  int jx[$];
  int jy[$];
  int ret_due[$];
  logic          pv = 1'b0, pr = 1'b0;
  logic [CW-1:0] px = '0, py = '0;

  always @(negedge clk) begin
    logic rdy;
    cyc++;
    if (rand_ready) rnd_ready = 1'($urandom_range(0, 1));
    rdy = rand_ready ? rnd_ready : fixed_ready;
    if (stab_en && pv && !pr && (!job_valid_o || job_x_o != px || job_y_o != py)) stab_bad++;
    pv = job_valid_o;
    pr = rdy;
    px = job_x_o;
    py = job_y_o;
    if (job_valid_o && rdy) begin
      jx.push_back(int'(job_x_o));
      jy.push_back(int'(job_y_o));
      if (ret_en) ret_due.push_back(cyc + 3);
    end
    auto_res = 1'b0;
    if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
      void'(ret_due.pop_front());
      auto_res = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [AW-1:0] a, input logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_wdata_i = d;
    tick();
    reg_req_i = 1'b0; reg_we_i = 1'b0;
    check("wr_rvalid", reg_rvalid_o, 1);
  endtask

  task automatic reg_read(input logic [AW-1:0] a, output logic [31:0] d);
    reg_req_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a;
    tick();
    reg_req_i = 1'b0;
    check("rd_rvalid", reg_rvalid_o, 1);
    d = reg_rdata_o;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check(name, d, exp);
  endtask

  task automatic pulse_res();
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int i = 0; i < maxc && busy_o; i++) tick();
    check(name, busy_o, 0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
    string         name;
  } vec_t;

  vec_t vt[20];

  initial begin
    int base;
    int bad;
    int ex1[4] = '{1, 2, 1, 2};
    int ey1[4] = '{1, 1, 2, 2};

    vt[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,    "ctrl_rst"};
    vt[1]  = '{1'b0, 12'h004, 32'h0,        32'h0,    "status_rst"};
    vt[2]  = '{1'b0, 12'h008, 32'h0,        32'h0,    "width_rst"};
    vt[3]  = '{1'b0, 12'h00C, 32'h0,        32'h0,    "height_rst"};
    vt[4]  = '{1'b0, 12'h010, 32'h0,        32'h0,    "count_rst"};
    vt[5]  = '{1'b1, 12'h008, 32'hFFFF1234, 32'h0,    "width_wr_rdata"};
    vt[6]  = '{1'b0, 12'h008, 32'h0,        32'h1234, "width_rd"};
    vt[7]  = '{1'b1, 12'h00C, 32'h0000ABCD, 32'h0,    "height_wr_rdata"};
    vt[8]  = '{1'b0, 12'h00F, 32'h0,        32'hABCD, "height_rd_lowbits"};
    vt[9]  = '{1'b1, 12'h000, 32'h4,        32'h0,    "ctrl_wr_irqen"};
    vt[10] = '{1'b0, 12'h000, 32'h0,        32'h4,    "ctrl_rd_irqen"};
    vt[11] = '{1'b1, 12'h000, 32'h0,        32'h0,    "ctrl_wr_clear"};
    vt[12] = '{1'b0, 12'h000, 32'h0,        32'h0,    "ctrl_rd_clear"};
    vt[13] = '{1'b1, 12'h010, 32'h55,       32'h0,    "count_wr"};
    vt[14] = '{1'b0, 12'h010, 32'h0,        32'h0,    "count_ro"};
    vt[15] = '{1'b1, 12'h020, 32'hFFFFFFFF, 32'h0,    "unmapped_wr"};
    vt[16] = '{1'b0, 12'h020, 32'h0,        32'h0,    "unmapped_rd"};
    vt[17] = '{1'b0, 12'h00A, 32'h0,        32'h1234, "width_rd_lowbits"};
    vt[18] = '{1'b1, 12'h004, 32'hE,        32'h0,    "status_w1c_wr"};
    vt[19] = '{1'b0, 12'h004, 32'h0,        32'h0,    "status_after_w1c"};

    // Reset state
    repeat (3) tick();
    check("rst_gnt", reg_gnt_o, 1);
    check("rst_rvalid", reg_rvalid_o, 0);
    check("rst_rdata", reg_rdata_o, 0);
    check("rst_valid", job_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_x", job_x_o, 0);
    check("rst_y", job_y_o, 0);
    rst = 1'b0;
    tick();
    check("idle_rvalid", reg_rvalid_o, 0);

    // Register file table
    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) begin
        reg_write(vt[i].addr, vt[i].wdata);
        check(vt[i].name, reg_rdata_o, vt[i].exp);
      end else begin
        read_chk(vt[i].name, vt[i].addr, vt[i].exp);
      end
    end

    // Basic 4x4 run with interrupt enabled
    fixed_ready = 1'b1; ret_en = 1'b1; base = jx.size();
    reg_write(12'h008, 4);
    reg_write(12'h00C, 4);
    reg_write(12'h000, 32'h5);
    check("t1_first_valid", job_valid_o, 1);
    check("t1_first_busy", busy_o, 1);
    check("t1_first_x", job_x_o, 1);
    check("t1_first_y", job_y_o, 1);
    wait_idle(100, "t1_done_timeout");
    check("t1_njobs", jx.size() - base, 4);
    for (int i = 0; i < 4 && base + i < jx.size(); i++) begin
      check("t1_job_x", jx[base+i], ex1[i]);
      check("t1_job_y", jy[base+i], ey1[i]);
    end
    read_chk("t1_count", 12'h010, 4);
    read_chk("t1_status", 12'h004, 32'h2);
    check("t1_irq_set", irq_o, 1);
    reg_write(12'h004, 32'h2);
    read_chk("t1_status_clr", 12'h004, 32'h0);
    check("t1_irq_clr", irq_o, 0);
    ret_en = 1'b0;

    // Credit stall on a 7x3 frame (5 jobs, credit limit 3)
    base = jx.size();
    reg_write(12'h008, 7);
    reg_write(12'h00C, 3);
    reg_write(12'h000, 32'h1);
    repeat (6) tick();
    check("t2_stall_njobs", jx.size() - base, 3);
    check("t2_stall_valid", job_valid_o, 0);
    check("t2_stall_x", job_x_o, 4);
    check("t2_stall_y", job_y_o, 1);
    pulse_res();
    check("t2_release_valid", job_valid_o, 1);
    check("t2_release_x", job_x_o, 4);
    pulse_res();  // coincides with the x=4 handshake
    check("t2_simul_valid", job_valid_o, 1);
    check("t2_simul_x", job_x_o, 5);
    tick();
    check("t2_drain_valid", job_valid_o, 0);
    check("t2_drain_busy", busy_o, 1);
    check("t2_njobs", jx.size() - base, 5);
    pulse_res();
    pulse_res();
    check("t2_busy_pending", busy_o, 1);
    pulse_res();
    check("t2_busy_done", busy_o, 0);
    read_chk("t2_count", 12'h010, 5);
    read_chk("t2_status", 12'h004, 32'h2);
    check("t2_irq_disabled", irq_o, 0);
    reg_write(12'h000, 32'h4);
    read_chk("t2_status_keep", 12'h004, 32'h2);
    check("t2_irq_enable", irq_o, 1);
    reg_write(12'h000, 32'h0);
    read_chk("t2_status_keep2", 12'h004, 32'h2);
    check("t2_irq_disable", irq_o, 0);
    reg_write(12'h004, 32'hE);

    // Random backpressure on a 6x6 frame
    base = jx.size();
    rand_ready = 1'b1; ret_en = 1'b1; stab_en = 1'b1;
    reg_write(12'h008, 6);
    reg_write(12'h00C, 6);
    reg_write(12'h000, 32'h1);
    wait_idle(1000, "t3_done_timeout");
    stab_en = 1'b0; rand_ready = 1'b0; fixed_ready = 1'b0;
    check("t3_stable", stab_bad, 0);
    check("t3_njobs", jx.size() - base, 16);
    bad = 0;
    for (int k = 0; k < 16 && base + k < jx.size(); k++)
      if (jx[base+k] != 1 + k % 4 || jy[base+k] != 1 + k / 4) bad++;
    check("t3_raster", bad, 0);
    read_chk("t3_count", 12'h010, 16);
    read_chk("t3_status", 12'h004, 32'h2);
    reg_write(12'h004, 32'hE);
    ret_en = 1'b0;

    // Degenerate sizes and the minimal 3x3 frame
    base = jx.size();
    fixed_ready = 1'b1;
    reg_write(12'h008, 2);
    reg_write(12'h00C, 10);
    reg_write(12'h000, 32'h1);
    check("t4_valid", job_valid_o, 0);
    check("t4_busy", busy_o, 0);
    repeat (3) tick();
    check("t4_nojobs", jx.size() - base, 0);
    read_chk("t4_status", 12'h004, 32'h6);
    reg_write(12'h004, 32'h6);
    read_chk("t4_status_clr", 12'h004, 32'h0);
    reg_write(12'h008, 3);
    reg_write(12'h00C, 2);
    reg_write(12'h000, 32'h1);
    read_chk("t4_h2_status", 12'h004, 32'h6);
    reg_write(12'h004, 32'h6);
    ret_en = 1'b1;
    reg_write(12'h00C, 3);
    reg_write(12'h000, 32'h1);
    wait_idle(50, "t4_3x3_timeout");
    check("t4_3x3_njobs", jx.size() - base, 1);
    if (jx.size() > base) begin
      check("t4_3x3_x", jx[base], 1);
      check("t4_3x3_y", jy[base], 1);
    end
    read_chk("t4_3x3_count", 12'h010, 1);
    read_chk("t4_3x3_status", 12'h004, 32'h2);
    reg_write(12'h004, 32'hE);
    ret_en = 1'b0; fixed_ready = 1'b0;

    // Stray result in IDLE: sets err, COUNT untouched
    pulse_res();
    read_chk("t6_stray_status", 12'h004, 32'h4);
    read_chk("t6_stray_count", 12'h010, 1);
    reg_write(12'h004, 32'h4);

    // Abort after 5 handshakes with 3 outstanding on a 10x10 frame
    base = jx.size();
    reg_write(12'h008, 10);
    reg_write(12'h00C, 10);
    reg_write(12'h000, 32'h1);
    check("t5_valid_wait", job_valid_o, 1);
    fixed_ready = 1'b1;
    repeat (3) tick();
    fixed_ready = 1'b0;
    pulse_res();
    pulse_res();
    fixed_ready = 1'b1;
    repeat (2) tick();
    fixed_ready = 1'b0;
    check("t5_njobs_pre", jx.size() - base, 5);
    reg_write(12'h000, 32'h2);
    check("t5_abort_valid", job_valid_o, 0);
    check("t5_abort_busy", busy_o, 1);
    fixed_ready = 1'b1;
    reg_write(12'h008, 32'h55);
    read_chk("t5_drain_status", 12'h004, 32'h1);
    pulse_res();
    pulse_res();
    check("t5_busy_pending", busy_o, 1);
    pulse_res();
    check("t5_busy_done", busy_o, 0);
    read_chk("t5_status", 12'h004, 32'hA);
    read_chk("t5_width_kept", 12'h008, 10);
    read_chk("t5_count", 12'h010, 5);
    check("t5_njobs_post", jx.size() - base, 5);
    bad = 0;
    for (int k = 0; k < 5 && base + k < jx.size(); k++)
      if (jx[base+k] != 1 + k || jy[base+k] != 1) bad++;
    check("t5_order", bad, 0);
    fixed_ready = 1'b0;
    reg_write(12'h004, 32'hE);

    // Start+abort together: abort wins while busy, start wins while idle
    base = jx.size();
    reg_write(12'h000, 32'h1);
    check("t5b_valid", job_valid_o, 1);
    reg_write(12'h000, 32'h3);
    check("t5b_abort_valid", job_valid_o, 0);
    check("t5b_abort_busy", busy_o, 1);
    read_chk("t5b_status_drain", 12'h004, 32'h1);
    read_chk("t5b_status_done", 12'h004, 32'hA);
    read_chk("t5b_count", 12'h010, 0);
    reg_write(12'h004, 32'hE);
    reg_write(12'h000, 32'h3);
    check("t5b_idle_start_wins", job_valid_o, 1);
    reg_write(12'h000, 32'h2);
    repeat (2) tick();
    check("t5b_nojobs", jx.size() - base, 0);
    reg_write(12'h004, 32'hE);
    reg_write(12'h000, 32'h2);
    read_chk("t5b_idle_abort_ignored", 12'h004, 32'h0);

    // Reset mid-run, then a late result from the lost run
    fixed_ready = 1'b1;
    reg_write(12'h000, 32'h1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fixed_ready = 1'b0;
    check("t7_busy", busy_o, 0);
    check("t7_valid", job_valid_o, 0);
    check("t7_x", job_x_o, 0);
    check("t7_y", job_y_o, 0);
    tick();
    read_chk("t7_width", 12'h008, 0);
    pulse_res();
    read_chk("t7_status", 12'h004, 32'h4);
    read_chk("t7_count", 12'h010, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
